input_conditioner: RTL and testbench



---
 rtl/input_cond_pkg.sv | 35 +++
 rtl/input_conditioner_if.sv | 33 +++
 rtl/debounce_channel.sv | 114 +++++++++++
 rtl/input_conditioner.sv | 90 +++++++++
 tb/tb_input_conditioner.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/input_cond_pkg.sv
// Shared types, constants and helpers for the input_conditioner block.
package input_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        CHECK_LOW   = 2'b11
    } deb_state_t;

    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;
    localparam int unsigned GLITCH_W         = 8;
    localparam int unsigned DBG_W            = 4;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    // Debug view of both channel FSMs, P channel in the upper half.
    typedef struct packed {
        deb_state_t p_state;
        deb_state_t t_state;
    } cond_dbg_t;

    // Adds 0..3 to the glitch count without wrapping past GLITCH_MAX.
    function automatic logic [GLITCH_W-1:0] glitch_sat_add(
        input logic [GLITCH_W-1:0] cnt,
        input logic [1:0]          inc
    );
        logic [GLITCH_W:0] sum;
        sum = {1'b0, cnt} + (GLITCH_W+1)'(inc);
        if (sum > {1'b0, GLITCH_MAX}) begin
            return GLITCH_MAX;
        end
        return sum[GLITCH_W-1:0];
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side bundle of input_conditioner: raw board inputs in, conditioned
// authentication-FSM inputs and debug status out.
interface input_conditioner_if;

    logic                                 btn_t_raw;
    logic                                 sw_p_raw;
    logic                                 T;
    logic                                 P;
    logic                                 t_level;
    logic [input_cond_pkg::GLITCH_W-1:0]  glitch_cnt;
    logic [input_cond_pkg::DBG_W-1:0]     cond_dbg;

    modport master (
        output btn_t_raw,
        output sw_p_raw,
        input  T,
        input  P,
        input  t_level,
        input  glitch_cnt,
        input  cond_dbg
    );

    modport slave (
        input  btn_t_raw,
        input  sw_p_raw,
        output T,
        output P,
        output t_level,
        output glitch_cnt,
        output cond_dbg
    );

endinterface

// File: rtl/debounce_channel.sv
// One conditioning channel: 2-flop synchroniser, then a four-state debounce
// FSM that accepts a new level only after it holds for DEBOUNCE_CYCLES clocks.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_raw,
    output logic       level,
    output logic       rise_pulse,
    output logic       reject,
    output deb_state_t state
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    deb_state_t       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_level_next;
    logic             w_sync;

    assign w_sync = r_sync[1];

    // Metastability guard for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
        end
    end

    // A CHECK state either reverts (reject) or commits once the count drains.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            STABLE_LOW: begin
                if (w_sync) begin
                    w_state_next = CHECK_HIGH;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            CHECK_HIGH: begin
                if (!w_sync) begin
                    w_state_next = STABLE_LOW;
                end else if (r_cnt == '0) begin
                    w_state_next = STABLE_HIGH;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!w_sync) begin
                    w_state_next = CHECK_LOW;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            CHECK_LOW: begin
                if (w_sync) begin
                    w_state_next = STABLE_HIGH;
                end else if (r_cnt == '0) begin
                    w_state_next = STABLE_LOW;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = STABLE_LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        rise_pulse   = 1'b0;
        reject       = 1'b0;
        w_level_next = 1'b0;
        if ((r_state == CHECK_HIGH) && (w_state_next == STABLE_HIGH)) begin
            rise_pulse = 1'b1;
        end
        if (((r_state == CHECK_HIGH) && (w_state_next == STABLE_LOW)) ||
            ((r_state == CHECK_LOW)  && (w_state_next == STABLE_HIGH))) begin
            reject = 1'b1;
        end
        if ((w_state_next == STABLE_HIGH) || (w_state_next == CHECK_LOW)) begin
            w_level_next = 1'b1;
        end
    end

    assign level = r_level;
    assign state = r_state;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the step button (T pulse) and PIN switch (P level) for the
// authentication FSM. Define INPUT_COND_GLITCH_CNT_EN to count rejected bounces.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input_conditioner_if.slave  bus
);

    logic       w_t_level;
    logic       w_t_rise;
    logic       w_t_reject;
    deb_state_t w_t_state;
    logic       w_p_level;
    logic       w_p_rise;
    logic       w_p_reject;
    deb_state_t w_p_state;
    cond_dbg_t  w_dbg;
    logic       r_t;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_t_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_raw      (bus.btn_t_raw),
        .level      (w_t_level),
        .rise_pulse (w_t_rise),
        .reject     (w_t_reject),
        .state      (w_t_state)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_p_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_raw      (bus.sw_p_raw),
        .level      (w_p_level),
        .rise_pulse (w_p_rise),
        .reject     (w_p_reject),
        .state      (w_p_state)
    );

    // T is high only in the cycle the T channel commits to STABLE_HIGH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= 1'b0;
        end else begin
            r_t <= w_t_rise;
        end
    end

`ifdef INPUT_COND_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch_cnt;
    logic [1:0]          w_rej_inc;
    logic                w_unused_p_rise;

    assign w_rej_inc       = 2'(w_t_reject) + 2'(w_p_reject);
    assign w_unused_p_rise = w_p_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else begin
            r_glitch_cnt <= glitch_sat_add(r_glitch_cnt, w_rej_inc);
        end
    end

    assign bus.glitch_cnt = r_glitch_cnt;
`else
    logic w_unused_sigs;

    // The switch has no edge output and rejects are not counted in this build.
    assign w_unused_sigs  = &{1'b0, w_p_rise, w_t_reject, w_p_reject};
    assign bus.glitch_cnt = 8'd0;
`endif

    assign w_dbg.p_state = w_p_state;
    assign w_dbg.t_state = w_t_state;

    assign bus.T        = r_t;
    assign bus.P        = w_p_level;
    assign bus.t_level  = w_t_level;
    assign bus.cond_dbg = w_dbg;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned NV  = 11;
`ifdef INPUT_COND_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    typedef struct {
        logic        btn;
        logic        sw;
        int unsigned hold;
        int unsigned t_off;
        int unsigned tl_off;
        int unsigned p_off;
        int          gc_add;
        bit          chk_gc;
        string       name;
    } vec_t;

    typedef struct {
        int unsigned at;
        logic        t;
        logic        tl;
        logic        p;
        int          gc;
        bit          chk_gc;
        logic [3:0]  dbg;
        bit          chk_dbg;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_rej = 0;
    logic        cur_tl = 1'b0;
    logic        cur_p  = 1'b0;
    vec_t        tbl [NV];
    exp_t        exp_q [$];

    input_conditioner_if ifc ();

    input_conditioner #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gexp(int n);
        if (!GC_EN) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    function automatic void cmp(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endfunction

    task automatic push(int unsigned at, logic t, logic tl, logic p, int gc, bit chk_gc,
                        logic [3:0] dbg, bit chk_dbg, string name);
        exp_t e;
        int   i;
        e.at = at; e.t = t; e.tl = tl; e.p = p; e.gc = gc; e.chk_gc = chk_gc;
        e.dbg = dbg; e.chk_dbg = chk_dbg; e.name = name;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].at > at) i--;
        exp_q.insert(i, e);
    endtask

    // Scoreboard: pop every expectation due this cycle and compare.
    always @(negedge clk) begin : mon
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            if (e.at != cyc) begin
                cmp({e.name, ".late"}, int'(cyc), int'(e.at));
            end else begin
                cmp({e.name, ".T"}, int'(ifc.T), int'(e.t));
                cmp({e.name, ".t_level"}, int'(ifc.t_level), int'(e.tl));
                cmp({e.name, ".P"}, int'(ifc.P), int'(e.p));
                if (e.chk_gc)  cmp({e.name, ".glitch_cnt"}, int'(ifc.glitch_cnt), e.gc);
                if (e.chk_dbg) cmp({e.name, ".cond_dbg"}, int'(ifc.cond_dbg), int'(e.dbg));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic b, logic s);
        ifc.btn_t_raw = b;
        ifc.sw_p_raw  = s;
    endtask

    task automatic run_vec(vec_t v);
        int unsigned c0;
        logic        etl;
        logic        ep;
        c0 = cyc;
        drive(v.btn, v.sw);
        n_rej += v.gc_add;
        for (int unsigned k = 1; k <= v.hold; k++) begin
            etl = (v.tl_off != 0 && k >= v.tl_off) ? v.btn : cur_tl;
            ep  = (v.p_off  != 0 && k >= v.p_off)  ? v.sw  : cur_p;
            push(c0 + k, (k == v.t_off), etl, ep, gexp(n_rej), v.chk_gc && (k == v.hold),
                 4'd0, 1'b0, v.name);
        end
        if (v.tl_off != 0) cur_tl = v.btn;
        if (v.p_off  != 0) cur_p  = v.sw;
        repeat (v.hold) tick();
    endtask

    // Both levels high: drop the selected channels for 2 clocks so each rejects once.
    task automatic bounce(bit dt, bit dp, string name);
        int unsigned c0;
        int          g0;
        logic [3:0]  dchk;
        c0 = cyc;
        g0 = gexp(n_rej);
        drive(!dt, !dp);
        n_rej += int'(dt) + int'(dp);
        dchk = {dp ? 2'b11 : 2'b10, dt ? 2'b11 : 2'b10};
        for (int unsigned k = 1; k <= 6; k++) begin
            push(c0 + k, 1'b0, 1'b1, 1'b1, (k == 6) ? gexp(n_rej) : g0, 1'b1,
                 (k == 3 || k == 4) ? dchk : 4'b1010, 1'b1, name);
        end
        tick();
        tick();
        drive(1'b1, 1'b1);
        repeat (4) tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned c0;
        int unsigned m;

        tbl[0]  = '{1'b1, 1'b0, 20, 7, 7, 0, 0, 1'b1, "press"};
        tbl[1]  = '{1'b0, 1'b0, 12, 0, 7, 0, 0, 1'b1, "release"};
        tbl[2]  = '{1'b0, 1'b1, 12, 0, 0, 7, 0, 1'b1, "sw_on"};
        tbl[3]  = '{1'b0, 1'b0,  3, 0, 0, 0, 0, 1'b0, "sw_glitch"};
        tbl[4]  = '{1'b0, 1'b1, 10, 0, 0, 0, 1, 1'b1, "sw_restore"};
        tbl[5]  = '{1'b1, 1'b1,  2, 0, 0, 0, 0, 1'b0, "bounce_a1"};
        tbl[6]  = '{1'b0, 1'b1,  2, 0, 0, 0, 0, 1'b0, "bounce_a0"};
        tbl[7]  = '{1'b1, 1'b1,  2, 0, 0, 0, 0, 1'b0, "bounce_b1"};
        tbl[8]  = '{1'b0, 1'b1,  2, 0, 0, 0, 0, 1'b0, "bounce_b0"};
        tbl[9]  = '{1'b1, 1'b1, 20, 7, 7, 0, 2, 1'b1, "bounce_hold"};
        tbl[10] = '{1'b0, 1'b1, 12, 0, 7, 0, 0, 1'b1, "release2"};

        rst_n = 1'b1;
        drive(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp("reset.T", int'(ifc.T), 0);
        cmp("reset.t_level", int'(ifc.t_level), 0);
        cmp("reset.P", int'(ifc.P), 0);
        cmp("reset.glitch_cnt", int'(ifc.glitch_cnt), 0);
        cmp("reset.cond_dbg", int'(ifc.cond_dbg), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();

        for (int v = 0; v < int'(NV); v++) run_vec(tbl[v]);

        // Reset pulse while the T channel is in CHECK_HIGH with the button held.
        c0 = cyc;
        drive(1'b1, 1'b1);
        push(c0 + 3, 1'b0, 1'b0, 1'b1, gexp(n_rej), 1'b1, 4'b1001, 1'b1, "rst_pre");
        repeat (4) tick();
        rst_n = 1'b0;
        cur_tl = 1'b0;
        cur_p  = 1'b0;
        n_rej  = 0;
        push(cyc, 1'b0, 1'b0, 1'b0, 0, 1'b1, 4'd0, 1'b1, "rst_mid");
        tick();
        rst_n = 1'b1;
        m = cyc;
        for (int unsigned k = 1; k <= 9; k++) begin
            push(m + k, (k == 7), (k >= 7), (k >= 7), gexp(n_rej), (k == 9),
                 (k >= 7) ? 4'b1010 : ((k >= 3) ? 4'b0101 : 4'b0000), 1'b1, "rst_rel");
        end
        repeat (9) tick();
        cur_tl = 1'b1;
        cur_p  = 1'b1;

        bounce(1'b1, 1'b1, "simul");
        repeat (252) bounce(1'b1, 1'b0, "t_rej");
        bounce(1'b1, 1'b1, "simul_sat");
        repeat (48) bounce(1'b1, 1'b0, "sat_hold");

        repeat (3) tick();
        cmp("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
